// File: rtl/acc_control_unit_if.sv
// Control-unit <-> datapath/memory bundle for the 8-bit accumulator CPU.
// master = sequencer side (drives ALU control, strobes, PC); slave = datapath side.
interface acc_control_unit_if #(
    parameter int PC_W   = 4,
    parameter int ADDR_W = 4
);
    logic              run;
    logic [7:0]        instr;
    logic              acc_zero;
    logic [PC_W-1:0]   imem_addr;
    logic [2:0]        alu_op;
    logic              alu_en;
    logic              alu_src_imm;
    logic              acc_we;
    logic              acc_src_mem;
    logic [ADDR_W-1:0] dmem_addr;
    logic              dmem_re;
    logic              dmem_we;
    logic              halted;
    logic              illegal;

    modport master (
        input  run, instr, acc_zero,
        output imem_addr, alu_op, alu_en, alu_src_imm, acc_we, acc_src_mem,
               dmem_addr, dmem_re, dmem_we, halted, illegal
    );

    modport slave (
        output run, instr, acc_zero,
        input  imem_addr, alu_op, alu_en, alu_src_imm, acc_we, acc_src_mem,
               dmem_addr, dmem_re, dmem_we, halted, illegal
    );
endinterface

// File: rtl/acc_control_unit.sv
// Multi-cycle fetch/decode/exec sequencer for the 8-bit accumulator CPU (CU_ILLEGAL_TRAP_EN traps opcodes D/E).
// Latency: 2 cycles NOP/STA/JMP/JZ/HLT, 3 immediate ALU ops, 4 memory ALU ops and LDA.
// Backpressure: none; memory is fixed-latency and all outputs are Moore-decoded from state and ir.
module acc_control_unit #(
    parameter int PC_W   = 4,
    parameter int ADDR_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    acc_control_unit_if.master  bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_EXEC   = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_SUBI = 4'h6;
    localparam logic [3:0] OP_ANDI = 4'h7;
    localparam logic [3:0] OP_ORI  = 4'h8;
    localparam logic [3:0] OP_LDA  = 4'h9;
    localparam logic [3:0] OP_STA  = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_JZ   = 4'hC;
    localparam logic [3:0] OP_UNDD = 4'hD;
    localparam logic [3:0] OP_UNDE = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    logic [2:0]      state;
    logic [PC_W-1:0] pc;
    logic [7:0]      ir;
    logic [3:0]      opc;
    logic [PC_W-1:0] jmp_tgt;

    assign opc     = ir[7:4];
    assign jmp_tgt = PC_W'(ir[3:0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc    <= '0;
            ir    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.run) state <= S_FETCH;
                end
                S_FETCH: begin
                    ir    <= bus.instr;
                    pc    <= pc + PC_W'(1);
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    case (opc)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LDA: state <= S_MEM;
                        OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI:     state <= S_EXEC;
                        OP_JMP: begin
                            pc    <= jmp_tgt;
                            state <= S_FETCH;
                        end
                        OP_JZ: begin
                            // acc_zero here reflects the previous instruction's writeback
                            if (bus.acc_zero) pc <= jmp_tgt;
                            state <= S_FETCH;
                        end
                        OP_HLT: state <= S_HALT;
                        OP_UNDD, OP_UNDE: begin
`ifdef CU_ILLEGAL_TRAP_EN
                            state <= S_HALT;
`else
                            state <= S_FETCH;
`endif
                        end
                        default: state <= S_FETCH;
                    endcase
                end
                S_MEM:   state <= S_EXEC;
                S_EXEC:  state <= S_FETCH;
                S_HALT:  state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CU_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else if (state == S_DECODE && (opc == OP_UNDD || opc == OP_UNDE)) begin
            illegal_q <= 1'b1;
        end
    end

    assign bus.illegal = illegal_q;
`else
    assign bus.illegal = 1'b0;
`endif

    logic [2:0] alu_op_c;
    logic       alu_en_c;
    logic       alu_src_imm_c;
    logic       acc_we_c;
    logic       acc_src_mem_c;
    logic       dmem_re_c;
    logic       dmem_we_c;

    always_comb begin
        alu_op_c      = 3'b000;
        alu_en_c      = 1'b0;
        alu_src_imm_c = 1'b0;
        acc_we_c      = 1'b0;
        acc_src_mem_c = 1'b0;
        dmem_re_c     = 1'b0;
        dmem_we_c     = 1'b0;
        case (state)
            S_DECODE: begin
                case (opc)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LDA: dmem_re_c = 1'b1;
                    OP_STA:                                dmem_we_c = 1'b1;
                    default: ;
                endcase
            end
            S_EXEC: begin
                case (opc)
                    OP_ADD, OP_ADDI: alu_op_c = 3'b001;
                    OP_SUB, OP_SUBI: alu_op_c = 3'b010;
                    OP_AND, OP_ANDI: alu_op_c = 3'b011;
                    OP_OR,  OP_ORI:  alu_op_c = 3'b100;
                    default:         alu_op_c = 3'b000;
                endcase
                if (opc == OP_LDA) begin
                    acc_we_c      = 1'b1;
                    acc_src_mem_c = 1'b1;
                end else if (opc >= OP_ADD && opc <= OP_ORI) begin
                    alu_en_c      = 1'b1;
                    acc_we_c      = 1'b1;
                    alu_src_imm_c = (opc >= OP_ADDI);
                end
            end
            default: ;
        endcase
    end

    assign bus.imem_addr   = pc;
    assign bus.dmem_addr   = ADDR_W'(ir[3:0]);
    assign bus.alu_op      = alu_op_c;
    assign bus.alu_en      = alu_en_c;
    assign bus.alu_src_imm = alu_src_imm_c;
    assign bus.acc_we      = acc_we_c;
    assign bus.acc_src_mem = acc_src_mem_c;
    assign bus.dmem_re     = dmem_re_c;
    assign bus.dmem_we     = dmem_we_c;
    assign bus.halted      = (state == S_HALT);
endmodule

// File: doc/acc_control_unit.md
Name: acc_control_unit

Overview:
- Multi-cycle control sequencer for the 8-bit accumulator CPU.
- Fetches 8-bit instructions, decodes them and drives the datapath: ALU op/enable, operand source, accumulator write, data-memory strobes and PC.
- It is the issuing side of the ALU control interface. It produces alu_op/alu_en; the ALU consumes them.

Parameters:
- PC_W, 4, program counter / instruction-memory address width.
- ADDR_W, 4, data-memory address width (equals instruction operand field width).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- run  input  1  start execution; sampled only in IDLE
- instr  input  8  instruction memory read data at imem_addr (combinational memory)
- acc_zero  input  1  accumulator == 0
- imem_addr  output  PC_W  current PC
- alu_op  output  3  001 ADD, 010 SUB, 011 AND, 100 OR, 000 otherwise
- alu_en  output  1  ALU perform operation
- alu_src_imm  output  1  1: operand = zero-extended ir[3:0]; 0: operand = dmem read data
- acc_we  output  1  write accumulator this cycle
- acc_src_mem  output  1  1: acc <= dmem data (LDA); 0: acc <= ALU result
- dmem_addr  output  ADDR_W  data-memory address (= ir[3:0])
- dmem_re  output  1  data-memory read request (data valid next cycle)
- dmem_we  output  1  data-memory write strobe (write data = acc)
- halted  output  1  core stopped
- illegal  output  1  illegal opcode trapped (feature only; tied 0 otherwise)

Behaviour:
- Instruction format: opcode = instr[7:4], operand = instr[3:0].
- Opcodes:
  - 0 NOP
  - 1 ADD m, 2 SUB m, 3 AND m, 4 OR m
  - 5 ADDI, 6 SUBI, 7 ANDI, 8 ORI
  - 9 LDA m, A STA m
  - B JMP, C JZ
  - F HLT
  - D, E undefined
- States: IDLE, FETCH, DECODE, MEM, EXEC, HALT. Encoding is implementer's choice.
- Reset (rst_n low at a clock edge), regardless of state:
  - state = IDLE, pc = 0, ir = 0.
  - All outputs 0 except imem_addr = 0 and dmem_addr = 0.
  - Reset mid-instruction aborts with no further strobes.
- IDLE: run = 1 goes to FETCH; otherwise stay.
- FETCH: ir <= instr; pc <= pc + 1, wrapping 2^PC_W-1 to 0. Next state DECODE.
- DECODE, by opcode:
  - NOP: next FETCH.
  - ADD/SUB/AND/OR/LDA: dmem_re = 1; next MEM.
  - ADDI..ORI: next EXEC.
  - STA: dmem_we = 1 for this cycle only; next FETCH.
  - JMP: pc <= ir[3:0] (zero-extended); next FETCH.
  - JZ: if acc_zero then pc <= ir[3:0], else pc unchanged; next FETCH.
  - HLT: next HALT.
  - D/E: treated as NOP (see feature).
- MEM: waits for memory data; dmem_re held 0. Next EXEC.
- EXEC: single cycle, then FETCH.
  - ALU ops: alu_en = 1, acc_we = 1, alu_op per table above.
  - alu_src_imm = 1 for the immediate forms, 0 for the memory forms.
  - LDA: acc_we = 1, acc_src_mem = 1, alu_en = 0.
- HALT: halted = 1; stays in HALT until reset. run is ignored.
- Outputs are Moore-decoded from state and ir.
  - dmem_addr = ir[3:0] in all states.
  - imem_addr = pc.
  - Strobes are 0 in every state/opcode combination not listed above.
- Cycles per instruction:
  - 2: NOP, STA, JMP, JZ.
  - 3: immediate ALU ops.
  - 4: memory ALU ops and LDA.
  - HLT: 2 cycles to enter HALT.
- acc_zero is sampled in DECODE. It therefore reflects the previous instruction's writeback.
- Never asserted together: dmem_re and dmem_we; acc_we and dmem_we.

Optional Feature:
- Macro: CU_ILLEGAL_TRAP_EN.
- Defined: opcode D or E in DECODE goes to HALT with illegal <= 1; both halted and illegal stay 1 until reset.
- Not defined: D/E execute as NOP (2 cycles); the illegal port exists but is tied 0.

Test Plan:
- Reset then run = 1, imem[0] = 0x53 (ADDI 3):
  - FETCH, DECODE, EXEC on cycles 1-3.
  - EXEC has alu_en = 1, alu_op = 001, alu_src_imm = 1, acc_we = 1.
  - imem_addr = 1 after FETCH.
- imem[0] = 0x27 (SUB m7):
  - dmem_re = 1 with dmem_addr = 7 in DECODE.
  - MEM cycle with no strobes.
  - EXEC alu_op = 010, alu_src_imm = 0, acc_we = 1.
- imem[0] = 0xC9 (JZ 9):
  - With acc_zero = 1, the next FETCH has imem_addr = 9.
  - With acc_zero = 0, the next FETCH has imem_addr = 1.
- PC wrap: 16 NOPs from pc = 0 -> imem_addr returns to 0 after the 16th FETCH; no strobes asserted.
- Sequence 0x95 (LDA 5), 0xA6 (STA 6), 0xF0 (HLT):
  - LDA EXEC has acc_we = 1, acc_src_mem = 1.
  - STA has dmem_we = 1 for exactly one cycle with dmem_addr = 6.
  - Then halted = 1 is held for 20 cycles with run toggling; rst_n = 0 for one edge returns to IDLE with all outputs 0.
- Reset mid-operation: rst_n = 0 in the MEM cycle of 0x1F -> no EXEC strobes; state IDLE; pc = 0.
- Opcode 0xE0:
  - With CU_ILLEGAL_TRAP_EN, halted = 1 and illegal = 1 after DECODE.
  - Without it, the next FETCH occurs at pc = 1.
